// File: rtl/dmem_arbiter_pkg.sv
// Shared codes for the data-memory arbiter: data-type codes, sequencer states
// and grant-owner codes.
package dmem_arbiter_pkg;

  localparam logic [2:0] DATATYPE_BYTE  = 3'd0;
  localparam logic [2:0] DATATYPE_HALF  = 3'd1;
  localparam logic [2:0] DATATYPE_WORD  = 3'd2;
  localparam logic [2:0] DATATYPE_UBYTE = 3'd4;
  localparam logic [2:0] DATATYPE_UHALF = 3'd5;

  typedef enum logic [1:0] {
    DMEM_IDLE    = 2'd0,
    DMEM_LD_RESP = 2'd1,
    DMEM_RMW_RD  = 2'd2,
    DMEM_RMW_WR  = 2'd3
  } dmem_state_e;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_EXT  = 1'b1;

  function automatic logic is_subword(input logic [2:0] dtype);
    return (dtype == DATATYPE_BYTE) || (dtype == DATATYPE_UBYTE) ||
           (dtype == DATATYPE_HALF) || (dtype == DATATYPE_UHALF);
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational store-lane merge: replaces the byte or halfword selected by
// addr_lo/dtype inside old_word; word-class codes return new_data unchanged.
module dmem_lane_merge
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DT_W   = 3
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  input  logic [1:0]        addr_lo,
  input  logic [DT_W-1:0]   dtype,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    case (dtype)
      DATATYPE_BYTE, DATATYPE_UBYTE: merged[8*addr_lo +: 8] = new_data[7:0];
      // addr_lo[0] is deliberately ignored for halfwords
      DATATYPE_HALF, DATATYPE_UHALF: merged[16*addr_lo[1] +: 16] = new_data[15:0];
      default:                       merged = new_data;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for the single-port data BRAM shared by the core and an
// external word-wide master. Optional macro: DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [DT_W-1:0]   core_dtype_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  dmem_state_e       state, state_nxt;
  logic              owner_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DT_W-1:0]   dtype_p1;
  logic              core_first;
  logic              pick_core, pick_ext;
  logic [DATA_W-1:0] merged;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_ext;

  // Resets to ext so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)                        last_ext <= 1'b1;
    else if (pick_core || pick_ext) last_ext <= pick_ext;
  end

  assign core_first = last_ext;
`else
  assign core_first = 1'b1;
`endif

  always_comb begin
    pick_core = 1'b0;
    pick_ext  = 1'b0;
    if (!rst && state == DMEM_IDLE) begin
      pick_core = core_req_i && (!ext_req_i || core_first);
      pick_ext  = ext_req_i && !pick_core;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DMEM_IDLE;
      owner_p1 <= OWNER_EXT;
    end else begin
      state <= state_nxt;
      if (pick_core)     owner_p1 <= OWNER_CORE;
      else if (pick_ext) owner_p1 <= OWNER_EXT;
    end
  end

  // Grant stage: only core stores can need read-modify-write, so only they are captured.
  always_ff @(posedge clk) begin
    if (pick_core) begin
      addr_p1  <= core_addr_i;
      wdata_p1 <= core_wdata_i;
      dtype_p1 <= core_dtype_i;
    end
  end

  dmem_lane_merge #(
    .DATA_W (DATA_W),
    .DT_W   (DT_W)
  ) u_lane_merge (
    .old_word (mem_rdata_i),
    .new_data (wdata_p1),
    .addr_lo  (addr_p1[1:0]),
    .dtype    (dtype_p1),
    .merged   (merged)
  );

  always_comb begin
    state_nxt     = state;
    core_gnt_o    = pick_core;
    ext_gnt_o     = pick_ext;
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    ext_rvalid_o  = 1'b0;
    ext_rdata_o   = '0;
    mem_en_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    core_stall_o  = 1'b0;
    if (!rst) begin
      core_stall_o = (core_req_i && !pick_core) ||
                     (state != DMEM_IDLE && owner_p1 == OWNER_CORE);
      case (state)
        DMEM_IDLE: begin
          if (pick_core) begin
            mem_en_o   = 1'b1;
            mem_addr_o = core_addr_i & WORD_MASK;
            if (!core_we_i) begin
              state_nxt = DMEM_LD_RESP;
            end else if (is_subword(core_dtype_i)) begin
              state_nxt = DMEM_RMW_RD;
            end else begin
              mem_we_o    = 1'b1;
              mem_wdata_o = core_wdata_i;
            end
          end else if (pick_ext) begin
            mem_en_o   = 1'b1;
            mem_addr_o = ext_addr_i & WORD_MASK;
            if (ext_we_i) begin
              mem_we_o    = 1'b1;
              mem_wdata_o = ext_wdata_i;
            end else begin
              state_nxt = DMEM_LD_RESP;
            end
          end
        end
        DMEM_LD_RESP: begin
          if (owner_p1 == OWNER_CORE) begin
            core_rvalid_o = 1'b1;
            core_rdata_o  = mem_rdata_i;
          end else begin
            ext_rvalid_o = 1'b1;
            ext_rdata_o  = mem_rdata_i;
          end
          state_nxt = DMEM_IDLE;
        end
        // BRAM enable stays low here so its output holds the old word into RMW_WR.
        DMEM_RMW_RD: state_nxt = DMEM_RMW_WR;
        DMEM_RMW_WR: begin
          mem_en_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_p1 & WORD_MASK;
          mem_wdata_o = merged;
          state_nxt   = DMEM_IDLE;
        end
        default: state_nxt = DMEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a word-array memory model and arithmetic lane-merge rules.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk, rst;
  logic        core_req_i, core_we_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [2:0]  core_dtype_i;
  logic        core_gnt_o, core_rvalid_o, core_stall_o;
  logic [31:0] core_rdata_o;
  logic        ext_req_i, ext_we_i;
  logic [31:0] ext_addr_i, ext_wdata_i;
  logic        ext_gnt_o, ext_rvalid_o;
  logic [31:0] ext_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [134:0] all_out;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bram [0:63];
  logic [31:0] bram_q;
  logic [31:0] ref_mem [0:63];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DT_W(3)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_dtype_i(core_dtype_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
    .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
    .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o),
    .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  assign all_out = {core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
                    ext_gnt_o, ext_rvalid_o, ext_rdata_o, mem_en_o, mem_we_o,
                    mem_addr_o, mem_wdata_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM: read data registered, held while not read-enabled.
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) bram[mem_addr_o[7:2]] <= mem_wdata_o;
      else          bram_q <= bram[mem_addr_o[7:2]];
    end
  end
  assign mem_rdata_i = bram_q;

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] addr,
                                            input logic [31:0] wd, input logic [2:0] dt);
    int sh;
    if (dt == DATATYPE_BYTE || dt == DATATYPE_UBYTE) begin
      sh = 8 * int'(addr % 4);
      return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (dt == DATATYPE_HALF || dt == DATATYPE_UHALF) begin
      sh = 16 * int'((addr / 2) % 2);
      return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic bit ref_sub(input logic [2:0] dt);
    return dt == DATATYPE_BYTE || dt == DATATYPE_UBYTE || dt == DATATYPE_HALF || dt == DATATYPE_UHALF;
  endfunction

  task automatic idle_inputs();
    core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0; core_dtype_i = 0;
    ext_req_i = 0; ext_we_i = 0; ext_addr_i = 0; ext_wdata_i = 0;
  endtask

  // Raises a request and returns #1 after the negedge of its grant cycle.
  task automatic issue(input bit ext, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] dt);
    int waited;
    @(negedge clk);
    if (ext) begin
      ext_req_i = 1; ext_we_i = we; ext_addr_i = addr; ext_wdata_i = wd;
    end else begin
      core_req_i = 1; core_we_i = we; core_addr_i = addr; core_wdata_i = wd; core_dtype_i = dt;
    end
    #1;
    waited = 0;
    while (!(ext ? ext_gnt_o : core_gnt_o) && waited < 40) begin
      @(negedge clk); #1; waited++;
    end
    vectors++;
    if (waited >= 40) begin
      miscompares++; $display("FAIL grant_wait ext=%0d: no grant after %0d cycles, required within 40", ext, waited);
    end
  endtask

  task automatic release_reqs();
    @(negedge clk);
    core_req_i = 0; ext_req_i = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    @(negedge clk);
    core_req_i = 1; core_we_i = 1; core_dtype_i = DATATYPE_WORD; ext_req_i = 1; #1;
    vectors++; if (all_out !== '0) begin miscompares++; $display("FAIL reset_req_held outputs %h required 0", all_out); end
    @(negedge clk); idle_inputs(); #1;
    vectors++; if (all_out !== '0) begin miscompares++; $display("FAIL reset_idle outputs %h required 0", all_out); end
    @(negedge clk); rst = 0; #1;
    vectors++; if (all_out !== '0) begin miscompares++; $display("FAIL post_reset outputs %h required 0", all_out); end
  endtask

  task automatic test_word_store_load();
    issue(0, 1, 32'h10, 32'hDEADBEEF, DATATYPE_WORD);
    vectors++;
    if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_stall_o} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0}) begin
      miscompares++; $display("FAIL ws_grant en=%b we=%b addr=%h wd=%h stall=%b required 1 1 10 deadbeef 0",
                              mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_stall_o);
    end
    ref_mem[4] = 32'hDEADBEEF;
    release_reqs();
    vectors++; if (mem_en_o !== 1'b0) begin miscompares++; $display("FAIL ws_after en=%b required 0", mem_en_o); end
    issue(0, 0, 32'h10, 32'h0, DATATYPE_WORD);
    vectors++;
    if ({mem_en_o, mem_we_o, core_rvalid_o} !== 3'b100) begin
      miscompares++; $display("FAIL ld_grant en/we/rvalid=%b%b%b required 100", mem_en_o, mem_we_o, core_rvalid_o);
    end
    release_reqs();
    vectors++;
    if ({core_rvalid_o, core_rdata_o, core_stall_o, ext_rvalid_o} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL ld_resp rvalid=%b rdata=%h stall=%b ext_rvalid=%b required 1 deadbeef 1 0",
                              core_rvalid_o, core_rdata_o, core_stall_o, ext_rvalid_o);
    end
    @(negedge clk); #1;
    vectors++; if (core_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL ld_done rvalid=%b required 0", core_rvalid_o); end
  endtask

  task automatic test_subword_store();
    logic [31:0] pre_a [6] = '{32'h20, 32'h30, 32'h30, 32'h24, 32'h28, 32'h2C};
    logic [31:0] st_a  [6] = '{32'h22, 32'h32, 32'h33, 32'h27, 32'h28, 32'h2C};
    logic [31:0] st_d  [6] = '{32'hAA, 32'hBEEF, 32'hBEEF, 32'hFFFFFF5A, 32'h12349876, 32'h77};
    logic [2:0]  st_t  [6] = '{DATATYPE_BYTE, DATATYPE_HALF, DATATYPE_HALF, DATATYPE_UBYTE, DATATYPE_UHALF, DATATYPE_BYTE};
    logic [31:0] exp_w [6] = '{32'h11AA3344, 32'hBEEF3344, 32'hBEEF3344, 32'h5A223344, 32'h11229876, 32'h11223377};
    for (int k = 0; k < 6; k++) begin
      issue(1, 1, pre_a[k], 32'h11223344, DATATYPE_WORD);
      release_reqs();
      issue(0, 1, st_a[k], st_d[k], st_t[k]);
      vectors++;
      if ({mem_en_o, mem_we_o, mem_addr_o, core_stall_o} !== {2'b10, pre_a[k], 1'b0}) begin
        miscompares++; $display("FAIL rmw_grant[%0d] en=%b we=%b addr=%h stall=%b required 1 0 %h 0",
                                k, mem_en_o, mem_we_o, mem_addr_o, core_stall_o, pre_a[k]);
      end
      release_reqs();
      vectors++;
      if ({mem_en_o, core_stall_o} !== 2'b01) begin
        miscompares++; $display("FAIL rmw_rd[%0d] en=%b stall=%b required 0 1", k, mem_en_o, core_stall_o);
      end
      @(negedge clk); #1;
      vectors++;
      if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_stall_o} !== {2'b11, pre_a[k], exp_w[k], 1'b1}) begin
        miscompares++; $display("FAIL rmw_wr[%0d] en=%b we=%b addr=%h wd=%h stall=%b required 1 1 %h %h 1",
                                k, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_stall_o, pre_a[k], exp_w[k]);
      end
      ref_mem[pre_a[k][7:2]] = exp_w[k];
      @(negedge clk); #1;
      vectors++;
      if ({mem_en_o, core_stall_o} !== 2'b00) begin
        miscompares++; $display("FAIL rmw_done[%0d] en=%b stall=%b required 0 0", k, mem_en_o, core_stall_o);
      end
      issue(1, 0, pre_a[k], 32'h0, DATATYPE_WORD);
      release_reqs();
      vectors++;
      if ({ext_rvalid_o, ext_rdata_o} !== {1'b1, exp_w[k]}) begin
        miscompares++; $display("FAIL rmw_readback[%0d] rvalid=%b rdata=%h required 1 %h", k, ext_rvalid_o, ext_rdata_o, exp_w[k]);
      end
    end
  endtask

  task automatic test_tie();
    logic [31:0] ca = 32'h20, ea = 32'h30;
    @(negedge clk);
    core_req_i = 1; core_we_i = 0; core_addr_i = ca; core_dtype_i = DATATYPE_WORD;
    ext_req_i = 1; ext_we_i = 0; ext_addr_i = ea; #1;
    vectors++;
    if ({core_gnt_o, ext_gnt_o} !== 2'b10) begin
      miscompares++; $display("FAIL tie1 core_gnt=%b ext_gnt=%b required 1 0", core_gnt_o, ext_gnt_o);
    end
    @(negedge clk); #1;
    vectors++;
    if ({core_rvalid_o, core_rdata_o, core_gnt_o, ext_gnt_o} !== {1'b1, ref_mem[ca[7:2]], 2'b00}) begin
      miscompares++; $display("FAIL tie1_resp rvalid=%b rdata=%h gnts=%b%b required 1 %h 00",
                              core_rvalid_o, core_rdata_o, core_gnt_o, ext_gnt_o, ref_mem[ca[7:2]]);
    end
    @(negedge clk); #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    vectors++;
    if ({core_gnt_o, ext_gnt_o, core_stall_o} !== 3'b011) begin
      miscompares++; $display("FAIL tie2_rr core_gnt=%b ext_gnt=%b stall=%b required 0 1 1", core_gnt_o, ext_gnt_o, core_stall_o);
    end
    @(negedge clk); ext_req_i = 0; #1;
    vectors++;
    if ({ext_rvalid_o, ext_rdata_o, core_gnt_o} !== {1'b1, ref_mem[ea[7:2]], 1'b0}) begin
      miscompares++; $display("FAIL tie2_ext_resp rvalid=%b rdata=%h core_gnt=%b required 1 %h 0",
                              ext_rvalid_o, ext_rdata_o, core_gnt_o, ref_mem[ea[7:2]]);
    end
    @(negedge clk); #1;
    vectors++; if (core_gnt_o !== 1'b1) begin miscompares++; $display("FAIL tie2_core_next gnt=%b required 1", core_gnt_o); end
    @(negedge clk); core_req_i = 0; #1;
    vectors++;
    if ({core_rvalid_o, core_rdata_o} !== {1'b1, ref_mem[ca[7:2]]}) begin
      miscompares++; $display("FAIL tie2_core_resp rvalid=%b rdata=%h required 1 %h", core_rvalid_o, core_rdata_o, ref_mem[ca[7:2]]);
    end
`else
    vectors++;
    if ({core_gnt_o, ext_gnt_o} !== 2'b10) begin
      miscompares++; $display("FAIL tie2_fixed core_gnt=%b ext_gnt=%b required 1 0", core_gnt_o, ext_gnt_o);
    end
    @(negedge clk); core_req_i = 0; #1;
    vectors++;
    if ({core_rvalid_o, core_rdata_o, ext_gnt_o} !== {1'b1, ref_mem[ca[7:2]], 1'b0}) begin
      miscompares++; $display("FAIL tie2_core_resp rvalid=%b rdata=%h ext_gnt=%b required 1 %h 0",
                              core_rvalid_o, core_rdata_o, ext_gnt_o, ref_mem[ca[7:2]]);
    end
    @(negedge clk); #1;
    vectors++; if (ext_gnt_o !== 1'b1) begin miscompares++; $display("FAIL tie2_ext_next gnt=%b required 1", ext_gnt_o); end
    @(negedge clk); ext_req_i = 0; #1;
    vectors++;
    if ({ext_rvalid_o, ext_rdata_o} !== {1'b1, ref_mem[ea[7:2]]}) begin
      miscompares++; $display("FAIL tie2_ext_resp rvalid=%b rdata=%h required 1 %h", ext_rvalid_o, ext_rdata_o, ref_mem[ea[7:2]]);
    end
`endif
  endtask

  task automatic test_ext_during_rmw();
    logic [31:0] expw;
    expw = ref_store(ref_mem[9], 32'h25, 32'h66, DATATYPE_BYTE);
    issue(0, 1, 32'h25, 32'h66, DATATYPE_BYTE);
    @(negedge clk);
    core_req_i = 0; ext_req_i = 1; ext_we_i = 0; ext_addr_i = 32'h24; #1;
    vectors++; if (ext_gnt_o !== 1'b0) begin miscompares++; $display("FAIL ext_in_rmw_rd gnt=%b required 0", ext_gnt_o); end
    @(negedge clk); #1;
    vectors++;
    if ({ext_gnt_o, mem_we_o, mem_wdata_o} !== {2'b01, expw}) begin
      miscompares++; $display("FAIL ext_in_rmw_wr gnt=%b we=%b wd=%h required 0 1 %h", ext_gnt_o, mem_we_o, mem_wdata_o, expw);
    end
    ref_mem[9] = expw;
    @(negedge clk); #1;
    vectors++; if (ext_gnt_o !== 1'b1) begin miscompares++; $display("FAIL ext_after_rmw gnt=%b required 1", ext_gnt_o); end
    release_reqs();
    vectors++;
    if ({ext_rvalid_o, ext_rdata_o} !== {1'b1, expw}) begin
      miscompares++; $display("FAIL ext_after_rmw_data rvalid=%b rdata=%h required 1 %h", ext_rvalid_o, ext_rdata_o, expw);
    end
  endtask

  task automatic test_reset_mid_rmw();
    issue(0, 1, 32'h2E, 32'h0000CAFE, DATATYPE_HALF);
    @(negedge clk); core_req_i = 0; rst = 1; #1;
    vectors++; if (all_out !== '0) begin miscompares++; $display("FAIL rst_in_rmw outputs %h required 0", all_out); end
    @(negedge clk); rst = 0; #1;
    vectors++; if (all_out !== '0) begin miscompares++; $display("FAIL rst_rmw_idle outputs %h required 0", all_out); end
    issue(1, 0, 32'h2C, 32'h0, DATATYPE_WORD);
    release_reqs();
    vectors++;
    if ({ext_rvalid_o, ext_rdata_o} !== {1'b1, ref_mem[11]}) begin
      miscompares++; $display("FAIL rst_rmw_readback rvalid=%b rdata=%h required 1 %h", ext_rvalid_o, ext_rdata_o, ref_mem[11]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, expw;
    logic [2:0]  dt;
    bit          ext, we;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      issue(1, 1, 32'h40 + 32'(i) * 4, d, DATATYPE_WORD);
      ref_mem[16 + i] = d;
      release_reqs();
    end
    for (int n = 0; n < 150; n++) begin
      ext = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      a   = 32'h40 + 32'($urandom_range(0, 63));
      d   = $urandom;
      dt  = 3'($urandom_range(0, 7));
      issue(ext, we, a, d, dt);
      vectors++;
      if (mem_en_o !== 1'b1 || mem_addr_o !== (a & ~32'h3)) begin
        miscompares++; $display("FAIL rnd_addr[%0d] en=%b addr=%h required 1 %h", n, mem_en_o, mem_addr_o, a & ~32'h3);
      end
      if (!we) begin
        release_reqs();
        vectors++;
        if ({core_rvalid_o, ext_rvalid_o, ext ? ext_rdata_o : core_rdata_o} !== {!ext, ext, ref_mem[a[7:2]]}) begin
          miscompares++; $display("FAIL rnd_load[%0d] ext=%0d rvalid c/e=%b%b rdata=%h required %h",
                                  n, ext, core_rvalid_o, ext_rvalid_o, ext ? ext_rdata_o : core_rdata_o, ref_mem[a[7:2]]);
        end
      end else if (!ext && ref_sub(dt)) begin
        expw = ref_store(ref_mem[a[7:2]], a, d, dt);
        release_reqs();
        @(negedge clk); #1;
        vectors++;
        if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, a & ~32'h3, expw}) begin
          miscompares++; $display("FAIL rnd_rmw[%0d] en=%b we=%b addr=%h wd=%h required 1 1 %h %h",
                                  n, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, a & ~32'h3, expw);
        end
        ref_mem[a[7:2]] = expw;
      end else begin
        vectors++;
        if ({mem_we_o, mem_wdata_o} !== {1'b1, d}) begin
          miscompares++; $display("FAIL rnd_wstore[%0d] we=%b wd=%h required 1 %h", n, mem_we_o, mem_wdata_o, d);
        end
        ref_mem[a[7:2]] = d;
        release_reqs();
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      issue(1, 0, 32'h40 + 32'(i) * 4, 32'h0, DATATYPE_WORD);
      release_reqs();
      vectors++;
      if ({ext_rvalid_o, ext_rdata_o} !== {1'b1, ref_mem[16 + i]}) begin
        miscompares++; $display("FAIL rnd_readback[%0d] rvalid=%b rdata=%h required 1 %h", i, ext_rvalid_o, ext_rdata_o, ref_mem[16 + i]);
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_tie();
    test_ext_during_rmw();
    test_reset_mid_rmw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequencer and arbiter for the single-port data BRAM shared by the core load/store path and an external word-wide bus master (program loader or debug port).
- Grants one requester at a time and handles the BRAM's 1-cycle read latency.
- Performs read-modify-write internally for byte and halfword stores, so the core never sees a partial write.
- Sits between the ex/mem stage logic and the BRAM; drives a stall to the pipeline while it is busy.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, BRAM word width; only 32 is supported.
- DT_W, 3, width of the data-type code.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- core_req_i  in  1  core access request
- core_we_i  in  1  1 = store, 0 = load
- core_addr_i  in  ADDR_W  byte address
- core_wdata_i  in  DATA_W  store data, right-aligned
- core_dtype_i  in  DT_W  byte/half/word/ubyte/uhalf code
- core_gnt_o  in/out: out  1  request accepted this cycle
- core_rvalid_o  out  1  load data valid
- core_rdata_o  out  DATA_W  raw BRAM word (extension is done downstream)
- core_stall_o  out  1  pipeline hold
- ext_req_i  in  1  external request; word access only
- ext_we_i  in  1  store/load
- ext_addr_i  in  ADDR_W  byte address
- ext_wdata_i  in  DATA_W  store data
- ext_gnt_o  out  1  accepted
- ext_rvalid_o  out  1  read data valid
- ext_rdata_o  out  DATA_W  read data
- mem_en_o  out  1  BRAM enable
- mem_we_o  out  1  BRAM write enable
- mem_addr_o  out  ADDR_W  word-aligned address; bits [1:0] always 0
- mem_wdata_o  out  DATA_W  BRAM write data
- mem_rdata_i  in  DATA_W  BRAM read data, valid the cycle after a read enable

Behaviour:
- Clocking/reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset: state = IDLE; every output is 0; the last-grant register points to ext, so the core wins the first tie.
- Grant: asserted only in IDLE, combinationally in the cycle of acceptance. The grant owner and its request fields are registered on grant.
- IDLE → LD_RESP (load):
  - mem_en=1, we=0 in the grant cycle.
  - In LD_RESP, rvalid=1 and rdata=mem_rdata_i for the granted requester, then return to IDLE.
  - Load latency is 1 cycle after grant.
- IDLE → IDLE (word store): mem_en=1, we=1, wdata passed through in the grant cycle.
- IDLE → RMW_RD (core byte/half store): mem_en=1, we=0 in the grant cycle.
- RMW_RD → RMW_WR: in RMW_WR, mem_en=1, we=1, wdata = mem_rdata_i with the selected lane replaced, then return to IDLE.
- Lane selection:
  - Byte lane = addr[1:0]; data = wdata[7:0] placed at bits 8*lane+7 : 8*lane.
  - Half lane = addr[1]; data = wdata[15:0] placed at bits 16*addr[1]+15 : 16*addr[1]. addr[0] is ignored.
  - ubyte/uhalf store codes are treated as byte/half.
  - Any other dtype with we=1 is treated as word.
- core_stall_o = core_req_i & ~(core_gnt_o) | (state != IDLE & owner == core).
- Arbitration: with both requests in IDLE, the core wins (see Optional Feature).
- A requester must hold req and its fields stable until gnt. Fields are sampled only at gnt.
- An ext request arriving during a core RMW waits; no preemption.
- Reset mid-RMW: abort to IDLE with no write issued. The memory word stays unmodified.
- Throughput: word store 1 cycle; load 2 cycles; sub-word store 3 cycles (grant, read, write).

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the requester not granted last. The last-grant register updates on every grant.
- Undefined: fixed priority, core always wins a tie. The last-grant register is not instantiated.

Decomposition:
- In the shared define file:
  - data-type codes (`datatype_byte/half/word/ubyte/uhalf`)
  - state encodings DMEM_IDLE, DMEM_LD_RESP, DMEM_RMW_RD, DMEM_RMW_WR (2 bits)
  - owner codes
- One sub-module, `dmem_lane_merge`: combinational; takes old word, new data, addr[1:0] and dtype, and returns the merged word. It is reusable by a future store buffer.

Test Plan:
- Core word store to 0x10 with 0xDEADBEEF, then core load of 0x10 → mem_we pulse in the grant cycle; rvalid 1 cycle after the load grant with rdata 0xDEADBEEF.
- Memory at 0x20 = 0x11223344; core byte store, addr 0x22, wdata 0xAA → three-cycle sequence read, then write 0x11AA3344; stall high for the 2 cycles following the grant.
- Memory at 0x30 = 0x11223344; half store, addr 0x32, wdata 0xBEEF → write 0xBEEF3344; addr 0x33 gives the same result.
- Simultaneous core and ext loads in IDLE → core granted first, ext granted next IDLE. With DMEM_ARB_ROUND_ROBIN_EN, a second tie grants ext.
- Ext request during a core RMW → ext_gnt stays 0 until the RMW_WR cycle completes, then ext_gnt=1 in the following IDLE.
- rst asserted in RMW_RD → next cycle IDLE with all outputs 0; the word at the target address is unchanged on readback.
